pipe_stage_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, freeze (stall) and flush. It generalises the fixed-width IF/ID register to any payload width and adds per-entry valid tracking. An optional two-entry skid buffer gives full throughput with a registered `in_ready`. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 18 +
 rtl/pipe_stage_reg_register.sv | 32 +++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
// Purpose : shared widths, types and helpers for the pipeline stage register.
//   ADDRESS_LEN  - architectural address width
//   IF_ID_WIDTH  - payload of the IF/ID stage (PC + instruction)
//   occ_t        - occupancy counter type (0..2)
//   occ_count()  - occupancy from the two entry valid bits
package pipe_stage_reg_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam int IF_ID_WIDTH = 2 * ADDRESS_LEN;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
  endfunction

endpackage

// File: rtl/pipe_stage_reg_register.sv
// pipe_stage_reg_register
// Purpose : loadable payload register with synchronous active-high reset.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous reset, loads RST_VAL
//   ld_i - load enable, captures d_i
//   d_i  - next payload
//   q_o  - stored payload
module pipe_stage_reg_register #(
  parameter int                     WORD_LENGTH = 64,
  parameter logic [WORD_LENGTH-1:0] RST_VAL     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_i,
  input  logic [WORD_LENGTH-1:0] d_i,
  output logic [WORD_LENGTH-1:0] q_o
);

  logic [WORD_LENGTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Purpose : parametrised pipeline stage register with valid/ready handshake,
//           freeze (stall) and flush. Strict FIFO order, occupancy 0..1, or
//           0..2 with the optional skid entry.
// Build option: define PIPE_REG_SKID_EN to add the skid entry, which makes
//           in_ready depend only on registered state and freeze.
// Ports   :
//   clk, rst              - clock, synchronous active-high reset
//   freeze                - stall: nothing accepted or released
//   flush                 - synchronous clear of all entries
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and head payload
//   count                 - occupancy
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH   = IF_ID_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Flush shares the reset path so both clear valids and payloads identically.
  logic clr;
  assign clr = rst | flush;

  logic             main_valid_q, main_valid_d;
  logic             main_ld;
  logic [WIDTH-1:0] main_d;
  logic             in_fire, out_fire;

  // Freeze already forces in_ready low, and gates out_fire here, so the
  // normal handshake logic alone guarantees all state holds while frozen.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready & ~freeze;

`ifdef PIPE_REG_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic             skid_ld;
  logic [WIDTH-1:0] skid_data;

  // Registered ready: the skid slot guarantees room for one beat in flight.
  assign in_ready = ~freeze & ~skid_valid_q;

  // Main refills from skid first to keep FIFO order, else from the input.
  assign main_ld = (out_fire & skid_valid_q) |
                   (in_fire & (~main_valid_q | out_fire));
  assign main_d  = (out_fire & skid_valid_q) ? skid_data : in_data;

  // Input goes to skid when main stays occupied after this edge.
  assign skid_ld = in_fire & main_valid_q & (~out_fire | skid_valid_q);

  assign main_valid_d = main_ld ? 1'b1 : (out_fire ? 1'b0 : main_valid_q);
  assign skid_valid_d = skid_ld ? 1'b1
                      : ((out_fire & skid_valid_q) ? 1'b0 : skid_valid_q);

  always_ff @(posedge clk) begin
    if (clr) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
  end

  pipe_stage_reg_register #(
    .WORD_LENGTH (WIDTH),
    .RST_VAL     (RST_VAL)
  ) u_skid_reg (
    .clk  (clk),
    .rst  (clr),
    .ld_i (skid_ld),
    .d_i  (in_data),
    .q_o  (skid_data)
  );

  assign count = occ_count(main_valid_q, skid_valid_q);
`else
  // Single entry: accept when empty or when the head leaves this cycle.
  assign in_ready = ~freeze & (~main_valid_q | out_ready);

  assign main_ld      = in_fire;
  assign main_d       = in_data;
  assign main_valid_d = main_ld ? 1'b1 : (out_fire ? 1'b0 : main_valid_q);

  assign count = occ_count(main_valid_q, 1'b0);
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      main_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
    end
  end

  pipe_stage_reg_register #(
    .WORD_LENGTH (WIDTH),
    .RST_VAL     (RST_VAL)
  ) u_main_reg (
    .clk  (clk),
    .rst  (clr),
    .ld_i (main_ld),
    .d_i  (main_d),
    .q_o  (out_data)
  );

  assign out_valid = main_valid_q;

endmodule
